// File: rtl/dcf77_frame_sequencer_if.sv
// rtl/dcf77_frame_sequencer_if.sv - signal bundle between DCF77 decoder, validity checker, software and the frame sequencer
interface dcf77_frame_sequencer_if;
    logic        bit_strobe;
    logic        bit_value;
    logic        minute_mark;
    logic        signal_valid;
    logic [58:0] dcf_bits;
    logic        dcf_new_sec;
    logic [58:0] frame_out;
    logic        frame_valid;
    logic        frame_ack;
    logic        overrun;
    logic        synced;

    // sequencer side
    modport slave (
        input  bit_strobe,
        input  bit_value,
        input  minute_mark,
        input  signal_valid,
        input  frame_ack,
        output dcf_bits,
        output dcf_new_sec,
        output frame_out,
        output frame_valid,
        output overrun,
        output synced
    );

    // decoder / checker / software side
    modport master (
        output bit_strobe,
        output bit_value,
        output minute_mark,
        output signal_valid,
        output frame_ack,
        input  dcf_bits,
        input  dcf_new_sec,
        input  frame_out,
        input  frame_valid,
        input  overrun,
        input  synced
    );
endinterface

// File: rtl/dcf77_frame_sequencer.sv
// rtl/dcf77_frame_sequencer.sv - DCF77 minute frame assembler/publisher, optional DCF77_REDUNDANCY_CHECK_EN
module dcf77_frame_sequencer #(
    parameter int unsigned CLOCK_FREQUENCY = 16000000
) (
    input  logic                   clk,
    input  logic                   reset,
    dcf77_frame_sequencer_if.slave bus
);
    localparam int unsigned TIMEOUT_CYCLES = 2 * CLOCK_FREQUENCY;
    localparam int          TIMER_W        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [5:0]  FRAME_BITS     = 6'd59;

    typedef enum logic {
        ST_SYNC    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [5:0]           cnt_q, cnt_d;
    logic [58:0]          shadow_q, shadow_d;
    logic [58:0]          dcf_bits_q, dcf_bits_d;
    logic                 new_sec_q, new_sec_d;
    logic [58:0]          frame_out_q, frame_out_d;
    logic                 frame_valid_q, frame_valid_d;
    logic                 overrun_q, overrun_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 enter_sync;
    logic                 collecting;
    logic                 check;
    logic                 publish;

`ifdef DCF77_REDUNDANCY_CHECK_EN
    // Only the fields the comparison needs are kept from the previous frame.
    logic [6:0]  ref_min_q, ref_min_d;
    logic [29:0] ref_hi_q, ref_hi_d;
    logic        ref_valid_q, ref_valid_d;
    logic [3:0]  ref_units;
    logic [2:0]  ref_tens;
    logic        ref_wrap;
    logic [6:0]  next_min;
    logic        ref_match;
`endif

    // Frame assembly: SYNC/COLLECT, bit counter, shadow capture, hand-off to the checker, idle timeout
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        dcf_bits_d = dcf_bits_q;
        new_sec_d  = 1'b0;
        timer_d    = timer_q;
        enter_sync = 1'b0;
        collecting = (state_q == ST_COLLECT);

        // The mark is handled first so a coincident strobe lands in the new frame.
        if (bus.minute_mark) begin
            if (collecting && (cnt_q == FRAME_BITS)) begin
                dcf_bits_d = shadow_q;
                new_sec_d  = 1'b1;
            end
            state_d    = ST_COLLECT;
            cnt_d      = '0;
            collecting = 1'b1;
        end

        if (bus.bit_strobe && collecting) begin
            if (cnt_d == FRAME_BITS) begin
                // A 60th second cannot belong to a valid minute: resynchronise.
                state_d    = ST_SYNC;
                cnt_d      = '0;
                enter_sync = 1'b1;
            end else begin
                for (int i = 0; i < 59; i++) begin
                    if (cnt_d == 6'(i)) shadow_d[i] = bus.bit_value;
                end
                cnt_d = cnt_d + 6'd1;
            end
        end

        // Loss of signal: no pulse of any kind for two seconds.
        if (bus.minute_mark || bus.bit_strobe || (state_q != ST_COLLECT)) begin
            timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
            timer_d    = '0;
            state_d    = ST_SYNC;
            cnt_d      = '0;
            enter_sync = 1'b1;
        end else begin
            timer_d = timer_q + TIMER_W'(1);
        end
    end

    // Publish path: checker verdict in the dcf_new_sec cycle, optional redundancy filter, ack/overrun
    always_comb begin
        check = new_sec_q && bus.signal_valid;

`ifdef DCF77_REDUNDANCY_CHECK_EN
        ref_units = ref_min_q[3:0];
        ref_tens  = ref_min_q[6:4];
        ref_wrap  = (ref_min_q == 7'h59);
        if (ref_wrap) begin
            next_min = 7'h00;
        end else if (ref_units == 4'd9) begin
            next_min = {ref_tens + 3'd1, 4'd0};
        end else begin
            next_min = {ref_tens, ref_units + 4'd1};
        end
        // The hour/date fields may legitimately change when the minute wraps.
        ref_match = ref_valid_q
                 && (dcf_bits_q[27:21] == next_min)
                 && (ref_wrap || (dcf_bits_q[58:29] == ref_hi_q));
        publish   = check && ref_match;

        ref_min_d   = check ? dcf_bits_q[27:21] : ref_min_q;
        ref_hi_d    = check ? dcf_bits_q[58:29] : ref_hi_q;
        ref_valid_d = enter_sync ? 1'b0 : (check ? 1'b1 : ref_valid_q);
`else
        publish = check;
`endif

        frame_out_d   = publish ? dcf_bits_q : frame_out_q;
        // A publish coinciding with the acknowledge keeps the new frame visible.
        frame_valid_d = publish ? 1'b1 : (bus.frame_ack ? 1'b0 : frame_valid_q);
        overrun_d     = overrun_q || (publish && frame_valid_q && !bus.frame_ack);
    end

    // State register; synchronous reset also drops any publish still in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_SYNC;
            cnt_q         <= '0;
            shadow_q      <= '0;
            dcf_bits_q    <= '0;
            new_sec_q     <= 1'b0;
            frame_out_q   <= '0;
            frame_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
            timer_q       <= '0;
`ifdef DCF77_REDUNDANCY_CHECK_EN
            ref_min_q     <= '0;
            ref_hi_q      <= '0;
            ref_valid_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            dcf_bits_q    <= dcf_bits_d;
            new_sec_q     <= new_sec_d;
            frame_out_q   <= frame_out_d;
            frame_valid_q <= frame_valid_d;
            overrun_q     <= overrun_d;
            timer_q       <= timer_d;
`ifdef DCF77_REDUNDANCY_CHECK_EN
            ref_min_q     <= ref_min_d;
            ref_hi_q      <= ref_hi_d;
            ref_valid_q   <= ref_valid_d;
`endif
        end
    end

    assign bus.dcf_bits    = dcf_bits_q;
    assign bus.dcf_new_sec = new_sec_q;
    assign bus.frame_out   = frame_out_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.overrun     = overrun_q;
    assign bus.synced      = (state_q == ST_COLLECT);
endmodule

// File: tb/tb_dcf77_frame_sequencer.sv
// tb/tb_dcf77_frame_sequencer.sv - self-checking bench for dcf77_frame_sequencer
module tb_dcf77_frame_sequencer;
    localparam int CF  = 100;
    localparam int TMO = 2 * CF;
    localparam logic [58:0] FA = 59'h5A5_A5A5_A5A5_A5A5;
    localparam logic [58:0] FB = 59'h0F0_F0F0_F0F0_F0F1;
    localparam logic [58:0] FC = 59'h7FF_0000_FFFF_0001;
    localparam logic [58:0] FD = 59'h3C3_C3C3_C3C3_C3C2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    dcf77_frame_sequencer_if bus();

    dcf77_frame_sequencer #(.CLOCK_FREQUENCY(CF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int ns_count = 0;
    int ns_base  = 0;
    int base     = 0;
    bit rnd_ack_en = 1'b0;

    always @(negedge clk) if (bus.dcf_new_sec === 1'b1) ns_count <= ns_count + 1;

    // reference model: frame as a list of received seconds
    bit          m_synced;
    bit          m_bits[$];
    logic [58:0] m_dcf, m_fo, m_ref;
    bit          m_fv, m_ov, m_refv;
    int          m_idle, m_ns;

    typedef struct {
        logic [58:0] frame;
        int          nbits;
        bit          sv;
        bit          ack_after;
        int          exp_ns;
        bit          exp_fv;
        bit          exp_ov;
        logic [58:0] exp_fo;
        bit          exp_synced;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_mark();
        logic [58:0] f;
        bit pub;
        int rm, fm;
        if (m_synced && m_bits.size() == 59) begin
            for (int i = 0; i < 59; i++) f[i] = m_bits[i];
            m_dcf = f;
            m_ns++;
            if (bus.signal_valid) begin
`ifdef DCF77_REDUNDANCY_CHECK_EN
                rm  = int'(m_ref[27:25]) * 10 + int'(m_ref[24:21]);
                fm  = int'(f[27:25]) * 10 + int'(f[24:21]);
                pub = m_refv && (fm == (rm + 1) % 60) && (rm == 59 || f[58:29] == m_ref[58:29]);
                m_ref  = f;
                m_refv = 1'b1;
`else
                rm  = 0;
                fm  = 0;
                pub = 1'b1;
`endif
                if (pub) begin
                    if (m_fv) m_ov = 1'b1;
                    m_fo = f;
                    m_fv = 1'b1;
                end
            end
        end
        m_synced = 1'b1;
        m_bits.delete();
    endtask

    task automatic model_step(input bit mark, input bit strobe, input bit val, input bit ack);
        if (ack) m_fv = 1'b0;
        if (mark) model_mark();
        if (strobe && m_synced) begin
            if (m_bits.size() < 59) m_bits.push_back(val);
            else begin
                m_synced = 1'b0;
                m_bits.delete();
                m_refv = 1'b0;
            end
        end
        if (mark || strobe) m_idle = 0;
        else if (m_synced) begin
            m_idle++;
            if (m_idle >= TMO) begin
                m_synced = 1'b0;
                m_bits.delete();
                m_refv = 1'b0;
                m_idle = 0;
            end
        end
    endtask

    task automatic cyc(input bit mark, input bit strobe, input bit val, input bit ack);
        bus.minute_mark = mark;
        bus.bit_strobe  = strobe;
        bus.bit_value   = val;
        bus.frame_ack   = ack;
        @(posedge clk);
        #1;
        bus.minute_mark = 1'b0;
        bus.bit_strobe  = 1'b0;
        bus.frame_ack   = 1'b0;
        model_step(mark, strobe, val, ack);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic mark_c();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_bits(input logic [58:0] f, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            cyc(1'b0, 1'b1, (i < 59) ? f[i] : 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, rnd_ack_en && ($urandom_range(0, 63) == 0));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.minute_mark = 1'b0;
        bus.bit_strobe  = 1'b0;
        bus.bit_value   = 1'b0;
        bus.frame_ack   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        m_synced = 1'b0; m_bits.delete(); m_dcf = '0; m_fo = '0; m_ref = '0;
        m_fv = 1'b0; m_ov = 1'b0; m_refv = 1'b0; m_idle = 0; m_ns = 0;
        ns_base = ns_count;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_synced"},   64'(bus.synced),      64'(m_synced));
        chk({tag, "_fv"},       64'(bus.frame_valid), 64'(m_fv));
        chk({tag, "_ov"},       64'(bus.overrun),     64'(m_ov));
        chk({tag, "_fo"},       64'(bus.frame_out),   64'(m_fo));
        chk({tag, "_dcf_bits"}, 64'(bus.dcf_bits),    64'(m_dcf));
        chk({tag, "_ns_count"}, 64'(ns_count - ns_base), 64'(m_ns));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [58:0] e, fr;
        int carried, n, rnd_min;
        logic [29:0] hi;
`ifndef DCF77_REDUNDANCY_CHECK_EN
        vec_t tbl[5];
        tbl[0] = '{frame: FA, nbits: 59, sv: 1'b1, ack_after: 1'b0, exp_ns: 1, exp_fv: 1'b1, exp_ov: 1'b0, exp_fo: FA, exp_synced: 1'b1};
        tbl[1] = '{frame: FB, nbits: 58, sv: 1'b1, ack_after: 1'b0, exp_ns: 0, exp_fv: 1'b1, exp_ov: 1'b0, exp_fo: FA, exp_synced: 1'b1};
        tbl[2] = '{frame: FB, nbits: 59, sv: 1'b1, ack_after: 1'b0, exp_ns: 1, exp_fv: 1'b1, exp_ov: 1'b1, exp_fo: FB, exp_synced: 1'b1};
        tbl[3] = '{frame: FC, nbits: 59, sv: 1'b0, ack_after: 1'b1, exp_ns: 1, exp_fv: 1'b0, exp_ov: 1'b1, exp_fo: FB, exp_synced: 1'b1};
        tbl[4] = '{frame: FA, nbits: 59, sv: 1'b1, ack_after: 1'b0, exp_ns: 1, exp_fv: 1'b1, exp_ov: 1'b1, exp_fo: FA, exp_synced: 1'b1};
`endif
        bus.signal_valid = 1'b0;
        do_reset();
        chk("rst_synced",   64'(bus.synced), 64'd0);
        chk("rst_fv",       64'(bus.frame_valid), 64'd0);
        chk("rst_ov",       64'(bus.overrun), 64'd0);
        chk("rst_fo",       64'(bus.frame_out), 64'd0);
        chk("rst_dcf_bits", 64'(bus.dcf_bits), 64'd0);
        chk("rst_new_sec",  64'(bus.dcf_new_sec), 64'd0);

        // strobe ignored in SYNC, mark enters COLLECT
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("sync_strobe_ignored", 64'(bus.synced), 64'd0);

`ifndef DCF77_REDUNDANCY_CHECK_EN
        // exact publish latency
        bus.signal_valid = 1'b1;
        mark_c(); idle(3);
        send_bits(FA, 0, 59);
        mark_c();
        chk("lat_new_sec_c1", 64'(bus.dcf_new_sec), 64'd1);
        chk("lat_fv_c1",      64'(bus.frame_valid), 64'd0);
        chk("lat_dcf_bits",   64'(bus.dcf_bits), 64'(FA));
        idle(1);
        chk("lat_new_sec_c2", 64'(bus.dcf_new_sec), 64'd0);
        chk("lat_fv_c2",      64'(bus.frame_valid), 64'd1);
        chk("lat_fo_c2",      64'(bus.frame_out), 64'(FA));

        // table of whole frames
        do_reset(); mark_c(); idle(3);
        for (int v = 0; v < 5; v++) begin
            bus.signal_valid = tbl[v].sv;
            base = ns_count;
            send_bits(tbl[v].frame, 0, tbl[v].nbits);
            mark_c(); idle(3);
            if (tbl[v].ack_after) begin
                cyc(1'b0, 1'b0, 1'b0, 1'b1);
                idle(1);
            end
            chk($sformatf("tbl%0d_ns", v),     64'(ns_count - base), 64'(tbl[v].exp_ns));
            chk($sformatf("tbl%0d_fv", v),     64'(bus.frame_valid), 64'(tbl[v].exp_fv));
            chk($sformatf("tbl%0d_ov", v),     64'(bus.overrun), 64'(tbl[v].exp_ov));
            chk($sformatf("tbl%0d_fo", v),     64'(bus.frame_out), 64'(tbl[v].exp_fo));
            chk($sformatf("tbl%0d_synced", v), 64'(bus.synced), 64'(tbl[v].exp_synced));
        end

        // ack in the publish cycle: publish wins, no overrun; plain ack clears next cycle
        do_reset(); bus.signal_valid = 1'b1;
        mark_c(); idle(3);
        send_bits(FA, 0, 59); mark_c(); idle(3);
        send_bits(FB, 0, 59); mark_c();
        cyc(1'b0, 1'b0, 1'b0, 1'b1); idle(2);
        chk("ackpub_fv", 64'(bus.frame_valid), 64'd1);
        chk("ackpub_ov", 64'(bus.overrun), 64'd0);
        chk("ackpub_fo", 64'(bus.frame_out), 64'(FB));
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ack_clears", 64'(bus.frame_valid), 64'd0);

        // coincident mark and strobe, checker rejects the closed frame
        do_reset(); bus.signal_valid = 1'b1;
        mark_c(); idle(3);
        send_bits(FA, 0, 59); mark_c(); idle(3);
        send_bits(FD, 0, 59);
        bus.signal_valid = 1'b0;
        base = ns_count;
        cyc(1'b1, 1'b1, 1'b1, 1'b0); idle(3);
        chk("coin_ns",       64'(ns_count - base), 64'd1);
        chk("coin_fv",       64'(bus.frame_valid), 64'd1);
        chk("coin_fo",       64'(bus.frame_out), 64'(FA));
        chk("coin_dcf_bits", 64'(bus.dcf_bits), 64'(FD));
        bus.signal_valid = 1'b1;
        e = {FC[58:1], 1'b1};
        send_bits(e, 1, 59); mark_c(); idle(3);
        chk("coin_bit0_fo", 64'(bus.frame_out), 64'(e));
        chk("coin_bit0_ov", 64'(bus.overrun), 64'd1);

        // reset in the check cycle suppresses the publish
        do_reset(); bus.signal_valid = 1'b1;
        mark_c(); idle(3);
        send_bits(FA, 0, 59); mark_c();
        do_reset(); idle(3);
        chk("rstchk_fv", 64'(bus.frame_valid), 64'd0);
        chk("rstchk_fo", 64'(bus.frame_out), 64'd0);
`else
        // redundancy: wrap 59 -> 00 publishes second frame only
        do_reset(); bus.signal_valid = 1'b1;
        mark_c(); idle(3);
        fr = FA; fr[27:21] = 7'h59;
        base = ns_count;
        send_bits(fr, 0, 59); mark_c(); idle(3);
        chk("red_first_ns", 64'(ns_count - base), 64'd1);
        chk("red_first_fv", 64'(bus.frame_valid), 64'd0);
        fr = FA; fr[27:21] = 7'h00; fr[20:0] = ~FA[20:0];
        send_bits(fr, 0, 59); mark_c(); idle(3);
        chk("red_wrap_fv", 64'(bus.frame_valid), 64'd1);
        chk("red_wrap_fo", 64'(bus.frame_out), 64'(fr));
        // 05 then 07 does not publish
        do_reset(); mark_c(); idle(3);
        fr = FB; fr[27:21] = 7'h05;
        send_bits(fr, 0, 59); mark_c(); idle(3);
        fr = FB; fr[27:21] = 7'h07;
        send_bits(fr, 0, 59); mark_c(); idle(3);
        chk("red_gap_fv", 64'(bus.frame_valid), 64'd0);
        fr = FB; fr[27:21] = 7'h08;
        send_bits(fr, 0, 59); mark_c(); idle(3);
        chk("red_seq_fv", 64'(bus.frame_valid), 64'd1);
        chk("red_seq_fo", 64'(bus.frame_out), 64'(fr));
        e = FB; e[27:21] = 7'h09; e[40] = ~e[40];
        send_bits(e, 0, 59); mark_c(); idle(3);
        chk("red_hi_fo", 64'(bus.frame_out), 64'(fr));
        chk("red_hi_ov", 64'(bus.overrun), 64'd0);
`endif

        // idle timeout and timer restart
        do_reset(); mark_c();
        idle(TMO - 1);
        chk("tmo_before", 64'(bus.synced), 64'd1);
        idle(1);
        chk("tmo_at", 64'(bus.synced), 64'd0);
        do_reset(); mark_c(); idle(150);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        idle(TMO - 1);
        chk("tmo_restart_before", 64'(bus.synced), 64'd1);
        idle(1);
        chk("tmo_restart_at", 64'(bus.synced), 64'd0);

        // 60th strobe without mark
        do_reset(); bus.signal_valid = 1'b1;
        mark_c(); idle(3);
        send_bits(FA, 0, 59);
        chk("ovf_before", 64'(bus.synced), 64'd1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("ovf_sync", 64'(bus.synced), 64'd0);
        base = ns_count;
        mark_c(); idle(3);
        chk("ovf_mark_ns", 64'(ns_count - base), 64'd0);

        // randomized frames against the model
        do_reset(); bus.signal_valid = 1'b1;
        mark_c(); idle(3);
        check_all("rnd_start");
        rnd_ack_en = 1'b1;
        carried = 0;
        rnd_min = int'($urandom_range(0, 59));
        hi = 30'($urandom);
        for (int fi = 0; fi < 14; fi++) begin
            fr = 59'({$urandom, $urandom});
            rnd_min = ($urandom_range(0, 5) == 0) ? (rnd_min + 2) % 60 : (rnd_min + 1) % 60;
            if ($urandom_range(0, 5) == 0) hi = 30'($urandom);
            fr[27:21] = {3'(rnd_min / 10), 4'(rnd_min % 10)};
            fr[58:29] = hi;
            n = ($urandom_range(0, 7) == 0) ? 58 : (($urandom_range(0, 7) == 0) ? 60 : 59);
            bus.signal_valid = ($urandom_range(0, 3) != 0);
            send_bits(fr, carried, n);
            if ($urandom_range(0, 4) == 0) begin
                cyc(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
                carried = 1;
            end else begin
                mark_c();
                carried = 0;
            end
            idle(3);
            check_all($sformatf("rnd%0d", fi));
        end
        rnd_ack_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dcf77_frame_sequencer.md
DCF77_FRAME_SEQUENCER -- requirements
Module: dcf77_frame_sequencer

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 16000000, clk frequency in Hz (timeout base).
REQ-002 SHALL have port clk  input  1  system clock; single clock domain; every register updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port bit_strobe  input  1  one-cycle pulse: one second's bit decoded.
REQ-005 SHALL have port bit_value  input  1  bit value, qualified by bit_strobe.
REQ-006 SHALL have port minute_mark  input  1  one-cycle pulse: missing-pulse minute gap detected.
REQ-007 SHALL have port signal_valid  input  1  combinational verdict from the validity checker for dcf_bits.
REQ-008 SHALL have port dcf_bits  output  59  frame held stable for the validity checker.
REQ-009 SHALL have port dcf_new_sec  output  1  one-cycle check strobe to the validity checker.
REQ-010 SHALL have port frame_out  output  59  last published frame.
REQ-011 SHALL have port frame_valid  output  1  frame_out holds an unacknowledged frame.
REQ-012 SHALL have port frame_ack  input  1  software acknowledge; clears frame_valid.
REQ-013 SHALL have port overrun  output  1  sticky: a frame was published while frame_valid was high.
REQ-014 SHALL have port synced  output  1  high in state COLLECT.

Function
REQ-015 SHALL implement states SYNC and COLLECT, plus a 6-bit bit counter cnt and a 59-bit shadow register.
REQ-016 In SYNC, bit_strobe SHALL be ignored; minute_mark SHALL set cnt=0 and move to COLLECT.
REQ-017 In COLLECT, bit_strobe with cnt<59 SHALL write shadow[cnt]=bit_value and increment cnt.
REQ-018 In COLLECT, bit_strobe with cnt==59 (frame overflow) SHALL move to SYNC and clear cnt.
REQ-019 In COLLECT, minute_mark with cnt==59 SHALL copy shadow to dcf_bits and assert dcf_new_sec in the next cycle only.
REQ-020 In COLLECT, minute_mark with cnt!=59 SHALL discard the shadow and set cnt=0, staying in COLLECT.
REQ-021 minute_mark and bit_strobe in the same cycle SHALL process the mark first; the strobe's bit SHALL be stored as shadow[0], with cnt=1.
REQ-022 In the cycle dcf_new_sec is high, signal_valid SHALL be sampled; low SHALL discard the frame (no publish).
REQ-023 Publish SHALL load frame_out=dcf_bits and set frame_valid=1 in the cycle after dcf_new_sec (two cycles after minute_mark).
REQ-024 frame_ack SHALL clear frame_valid next cycle; a publish in the same cycle as frame_ack SHALL win (frame_valid stays 1, no overrun).
REQ-025 Publish while frame_valid=1 and frame_ack=0 SHALL overwrite frame_out and set overrun; overrun SHALL clear only on reset.
REQ-026 Collection of the next frame SHALL continue during the check cycle; dcf_bits SHALL change only at REQ-019.
REQ-027 In COLLECT, no bit_strobe and no minute_mark for 2*CLOCK_FREQUENCY cycles SHALL move to SYNC; the timer SHALL restart on either pulse.

Reset
REQ-028 Reset SHALL force SYNC, cnt=0, shadow=0, dcf_bits=0, frame_out=0, dcf_new_sec=0, frame_valid=0, overrun=0, synced=0, timer=0, and clear the redundancy reference.
REQ-029 Reset asserted mid-frame or during the check cycle SHALL suppress any pending publish.

Configuration
REQ-030 Macro DCF77_REDUNDANCY_CHECK_EN defined: a checker-valid frame SHALL be published only if a stored reference exists and the frame matches it as follows:
- its BCD minute (bits 27:21) SHALL equal the reference minute +1, with 59 wrapping to 00;
- its bits 58:29 SHALL equal the reference's, except after a wrap.
REQ-031 With the macro defined, every checker-valid frame SHALL become the new reference; the first valid frame after reset or SYNC entry SHALL be stored but not published.
REQ-032 Macro undefined: every checker-valid frame SHALL be published; no reference register SHALL exist.

Verification
REQ-033 Reset, mark, 59 strobes, mark, signal_valid=1 -> dcf_new_sec one pulse, frame_out=frame, frame_valid=1 two cycles after the mark (macro off).
REQ-034 Mark after 58 bits -> no dcf_new_sec, cnt=0, synced stays 1.
REQ-035 Macro on, valid frames with minute 0x59 then 0x00 and equal 58:29 -> first frame not published, second published; minute 0x05 then 0x07 -> no publish.
REQ-036 Publish twice without frame_ack -> overrun=1, frame_out=second frame; frame_ack -> frame_valid=0 next cycle.
REQ-037 CLOCK_FREQUENCY=100, 200 idle cycles in COLLECT -> synced=0 at cycle 200; the 60th strobe without a mark -> SYNC.
REQ-038 minute_mark and bit_strobe(value 1) coincident -> shadow[0]=1, cnt=1; signal_valid=0 at check -> frame_valid unchanged.
